mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port, one-cycle-read-latency memory between the CPU's instruction-fetch path and its load/store path. It sits between the CPU datapath and a unified memory instance. It grants at most one access per cycle, returns read data to the winning requester one cycle later, and raises `stall` so the CPU holds the PC while a requester waits.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the response-owner encoding and the default starvation limit.
// Imported by the arbiter top and its winner-select sub-module.
package mem_arb_pkg;

  // Which requester, if any, receives mem_rdata in the current cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // Consecutive data grants tolerated while fetch waits (fixed-priority mode)
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU-side request/response and memory-side signals of the arbiter.
// slave = arbiter view, master = CPU datapath + memory environment view.
// Purely structural; no logic.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          stall;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// Zero latency; a lone requester always wins, contention resolved by fetch preference.
// Config macro MEM_ARB_RR_EN: preference comes from the round-robin pointer, else from the starvation flag.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic dm_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic rr_if_i,     // 1: fetch wins the next contended cycle
`else
  input  logic starve_i,    // 1: fetch has waited the maximum number of data grants
`endif
  output logic if_win_o,
  output logic dm_win_o
);

  logic fetch_pref;

`ifdef MEM_ARB_RR_EN
  assign fetch_pref = rr_if_i;
`else
  assign fetch_pref = starve_i;
`endif

  // Grant the single requester, or break the tie with the fetch preference
  always_comb begin
    if_win_o = 1'b0;
    dm_win_o = 1'b0;
    if (if_req_i && dm_req_i) begin
      if_win_o = fetch_pref;
      dm_win_o = ~fetch_pref;
    end else begin
      if_win_o = if_req_i;
      dm_win_o = dm_req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, 1-cycle-read memory between instruction fetch and load/store.
// Grant and mem_* in the request cycle; read data/rvalid one cycle later; 1 access/cycle.
// Losing requester sees stall and holds its request; config macro MEM_ARB_RR_EN selects round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);

  logic   if_gnt;
  logic   dm_gnt;
  owner_e rsp_owner_q, rsp_owner_d;

`ifdef MEM_ARB_RR_EN
  logic rr_if_q, rr_if_d;

  mem_arb_pick u_pick (
    .if_req_i (bus.if_req),
    .dm_req_i (bus.dm_req),
    .rr_if_i  (rr_if_q),
    .if_win_o (if_gnt),
    .dm_win_o (dm_gnt)
  );

  // Hand the next contended cycle to the other requester after each contended grant
  always_comb begin
    rr_if_d = rr_if_q;
    if (bus.if_req && bus.dm_req) rr_if_d = ~rr_if_q;
  end

  // Round-robin pointer register, starts pointing at data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_if_q <= 1'b0;
    else       rr_if_q <= rr_if_d;
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve;

  assign starve = (starve_cnt_q == CW'(STARVE_MAX));

  mem_arb_pick u_pick (
    .if_req_i (bus.if_req),
    .dm_req_i (bus.dm_req),
    .starve_i (starve),
    .if_win_o (if_gnt),
    .dm_win_o (dm_gnt)
  );

  // Count data grants that bypass a waiting fetch; any fetch grant or idle fetch clears it
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req || if_gnt) begin
      starve_cnt_d = '0;
    end else if (dm_gnt && !starve) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`endif

  // Next response owner: the read winner, otherwise nobody (writes and idle cycles)
  always_comb begin
    rsp_owner_d = OWN_NONE;
    if (if_gnt) begin
      rsp_owner_d = OWN_IF;
    end else if (dm_gnt && !bus.dm_we) begin
      rsp_owner_d = OWN_DM;
    end
  end

  // Response owner register; async reset drops any in-flight rvalid immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_owner_q <= OWN_NONE;
    else       rsp_owner_q <= rsp_owner_d;
  end

  // Memory port mux: forward the winner's request, drive zeros when idle
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    if (if_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr;
    end else if (dm_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dm_we;
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_rvalid = (rsp_owner_q == OWN_IF);
  assign bus.dm_rvalid = (rsp_owner_q == OWN_DM);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.stall     = (bus.if_req & ~if_gnt) | (bus.dm_req & ~dm_gnt);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic.
// A transaction-level model (grant rules, pending response, shadow memory) predicts every cycle.
// The bench also plays the 1-cycle-latency memory behind the arbiter.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Environment memory (what the arbiter actually talks to) and the model's shadow copy
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] ref_mem [256];

  // Reference model state
  int            starve;      // data grants taken while fetch waited
  bit            rr_if;       // round-robin: fetch wins the next contended cycle
  int            pend;        // 0 none, 1 fetch, 2 data response due this cycle
  logic [DW-1:0] pend_data;

  // Observations from the most recent step, for directed scenario checks
  logic          obs_if_gnt, obs_dm_gnt, obs_stall, obs_if_rvalid, obs_dm_rvalid;
  logic [DW-1:0] obs_if_rdata, obs_dm_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    starve = 0;
    rr_if  = 1'b0;
    pend   = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then act as memory and advance the model
  task automatic step();
    bit            fw, eif, edm;
    logic          cap_en, cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    fw = rr_if;
`else
    fw = (starve == SMAX);
`endif
    eif = bus.if_req && (!bus.dm_req || fw);
    edm = bus.dm_req && !eif;
    chk("if_gnt", bus.if_gnt, eif);
    chk("dm_gnt", bus.dm_gnt, edm);
    chk("stall", bus.stall, (bus.if_req && !eif) || (bus.dm_req && !edm));
    chk("mem_en", bus.mem_en, eif || edm);
    chk("mem_we", bus.mem_we, edm && bus.dm_we);
    if (eif) begin
      chk("mem_addr_if", bus.mem_addr, bus.if_addr);
    end else if (edm) begin
      chk("mem_addr_dm", bus.mem_addr, bus.dm_addr);
      if (bus.dm_we) chk("mem_wdata", bus.mem_wdata, bus.dm_wdata);
    end else begin
      chk("mem_addr_idle", bus.mem_addr, 0);
      chk("mem_wdata_idle", bus.mem_wdata, 0);
    end
    chk("if_rvalid", bus.if_rvalid, pend == 1);
    chk("dm_rvalid", bus.dm_rvalid, pend == 2);
    if (pend == 1) chk("if_rdata", bus.if_rdata, pend_data);
    if (pend == 2) chk("dm_rdata", bus.dm_rdata, pend_data);

    obs_if_gnt    = bus.if_gnt;
    obs_dm_gnt    = bus.dm_gnt;
    obs_stall     = bus.stall;
    obs_if_rvalid = bus.if_rvalid;
    obs_dm_rvalid = bus.dm_rvalid;
    obs_if_rdata  = bus.if_rdata;
    obs_dm_rdata  = bus.dm_rdata;
    cap_en        = bus.mem_en;
    cap_we        = bus.mem_we;
    cap_addr      = bus.mem_addr;
    cap_wdata     = bus.mem_wdata;

    @(posedge clk);
    #1;
    if (cap_en && cap_we) env_mem[cap_addr[9:2]] = cap_wdata;
    bus.mem_rdata = (cap_en && !cap_we) ? env_mem[cap_addr[9:2]] : DW'($urandom);

    pend = 0;
    if (eif) begin
      pend      = 1;
      pend_data = ref_mem[bus.if_addr[9:2]];
    end else if (edm) begin
      if (bus.dm_we) begin
        ref_mem[bus.dm_addr[9:2]] = bus.dm_wdata;
      end else begin
        pend      = 2;
        pend_data = ref_mem[bus.dm_addr[9:2]];
      end
    end
`ifdef MEM_ARB_RR_EN
    if (bus.if_req && bus.dm_req) rr_if = !rr_if;
`else
    if (!bus.if_req || eif) starve = 0;
    else if (edm && starve < SMAX) starve++;
`endif
    if (eif) bus.if_req = 1'b0;
    if (edm) bus.dm_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = DW'(i);
      ref_mem[i] = DW'(i);
    end
    model_reset();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_dm_gnt", bus.dm_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_dm_rvalid", bus.dm_rvalid, 0);
    chk("rst_stall", bus.stall, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back fetches 0x0, 0x4, 0x8
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    step();
    chk("fetch0_gnt", obs_if_gnt, 1);
    bus.if_req = 1'b1; bus.if_addr = 32'h4;
    step();
    chk("fetch1_gnt", obs_if_gnt, 1);
    chk("fetch0_data", obs_if_rdata, 0);
    bus.if_req = 1'b1; bus.if_addr = 32'h8;
    step();
    chk("fetch2_gnt", obs_if_gnt, 1);
    chk("fetch1_data", obs_if_rdata, 1);
    chk("fetch_stall", obs_stall, 0);
    step();
    chk("fetch2_rvalid", obs_if_rvalid, 1);
    chk("fetch2_data", obs_if_rdata, 2);

    // Data read contends with fetch; data wins first
    bus.if_req = 1'b1; bus.if_addr = 32'hC;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100;
    step();
    chk("cont_dm_gnt", obs_dm_gnt, 1);
    chk("cont_if_gnt", obs_if_gnt, 0);
    chk("cont_stall", obs_stall, 1);
    step();
    chk("cont_dm_rvalid", obs_dm_rvalid, 1);
    chk("cont_dm_rdata", obs_dm_rdata, 32'h40);
    chk("cont_if_gnt2", obs_if_gnt, 1);
    step();
    chk("cont_if_rvalid", obs_if_rvalid, 1);
    chk("cont_if_rdata", obs_if_rdata, 3);

    // Write then read back
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEADBEEF;
    step();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
    step();
    chk("wr_no_rvalid", obs_dm_rvalid, 0);
    step();
    chk("rd_rvalid", obs_dm_rvalid, 1);
    chk("rd_after_wr", obs_dm_rdata, 32'hDEADBEEF);

    // Reset in the cycle after a read grant
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h20;
    step();
    reset = 1'b1;
    #1;
    chk("arst_dm_rvalid", bus.dm_rvalid, 0);
    chk("arst_if_rvalid", bus.if_rvalid, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    chk("post_rst_rvalid", obs_dm_rvalid, 0);
    step();

    // Both requesters held high from a clean state
    for (int k = 0; k < 10; k++) begin
      bus.if_req = 1'b1; bus.if_addr = AW'(k * 4);
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = AW'($urandom_range(0, 255) * 4);
      step();
`ifdef MEM_ARB_RR_EN
      chk("rr_pattern", obs_if_gnt, (k % 2) == 1);
`else
      chk("starve_pattern", obs_if_gnt, (k % 5) == 4);
`endif
    end

    // Random traffic obeying the hold-until-grant handshake
    for (int c = 0; c < 400; c++) begin
      if (!bus.if_req && $urandom_range(0, 3) != 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = AW'($urandom_range(0, 255) * 4);
      end
      if (!bus.dm_req && $urandom_range(0, 2) != 0) begin
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'($urandom_range(0, 1));
        bus.dm_addr  = AW'($urandom_range(0, 255) * 4);
        bus.dm_wdata = DW'($urandom);
      end
      step();
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
